// File: rtl/wishbone_interconnect.sv
// -----------------------------------------------------------------------------
// wishbone_interconnect
//
// Single-controller to N-peripheral Wishbone classic interconnect. The upper
// pSelLen address bits pick a peripheral slot, the remaining bits are passed on
// as the local address. Each controller strobe gets exactly one ack. That ack
// comes from the selected peripheral, from the unmapped-address path (read data
// 0), or from a stall timeout (read data all ones, err=1).
//
// Optional build macro: WB_INTERCONNECT_STATUS_EN
//   When defined, slot 2**pSelLen-1 is an internal status register. A read
//   returns a saturating 8-bit timeout count. A write clears that count.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   wbc_*         controller side: stb/we/adr/dat in, rdat/ack/err out
//   wbp_stb       per-peripheral strobe (one-hot or zero)
//   wbp_we/adr/dat shared write enable, local address, write data
//   wbp_rdat      packed peripheral read data, slot i at [i*pDataLen +: pDataLen]
//   wbp_ack       per-peripheral ack
//   timeout_seen  sticky flag, set by any timeout, cleared only by reset
// -----------------------------------------------------------------------------
module wishbone_interconnect #(
  parameter int pAddrLen       = 4,
  parameter int pSelLen        = 2,
  parameter int pDataLen       = 8,
  parameter int pPeriCount     = 3,
  parameter int pTimeoutCycles = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wbc_stb,
  input  logic                           wbc_we,
  input  logic [pAddrLen-1:0]            wbc_adr,
  input  logic [pDataLen-1:0]            wbc_dat,
  output logic [pDataLen-1:0]            wbc_rdat,
  output logic                           wbc_ack,
  output logic                           wbc_err,
  output logic [pPeriCount-1:0]          wbp_stb,
  output logic                           wbp_we,
  output logic [pAddrLen-pSelLen-1:0]    wbp_adr,
  output logic [pDataLen-1:0]            wbp_dat,
  input  logic [pPeriCount*pDataLen-1:0] wbp_rdat,
  input  logic [pPeriCount-1:0]          wbp_ack,
  output logic                           timeout_seen
);

  localparam int LOC_LEN = pAddrLen - pSelLen;
  localparam int CNT_LEN = $clog2(pTimeoutCycles) + 1;
  localparam logic [CNT_LEN-1:0] CNT_LAST = CNT_LEN'(pTimeoutCycles - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    RESP     = 2'd2,
    WAIT_LOW = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [pSelLen-1:0]  sel_in, sel_q;
  logic [LOC_LEN-1:0]  adr_q;
  logic                we_q;
  logic [pDataLen-1:0] dat_q;
  logic [pDataLen-1:0] rdat_q;
  logic                err_q;
  logic [CNT_LEN-1:0]  cnt_q;
  logic                seen_q;

  logic                sel_mapped;
  logic                ack_hit;
  logic [pDataLen-1:0] slot_rdat;
  logic                cnt_done;
  logic                start;
  logic                timeout_evt;
  logic [pDataLen-1:0] idle_rdat;

  assign sel_in      = wbc_adr[pAddrLen-1 -: pSelLen];
  assign sel_mapped  = ({1'b0, sel_in} < (pSelLen + 1)'(pPeriCount));
  assign start       = (state_q == IDLE) && wbc_stb;
  assign cnt_done    = (cnt_q == CNT_LAST);
  // An ack arriving on the last allowed cycle beats the timeout.
  assign timeout_evt = (state_q == BUSY) && !ack_hit && cnt_done;

`ifdef WB_INTERCONNECT_STATUS_EN
  localparam logic [pSelLen-1:0] STATUS_SEL = '1;

  if (pPeriCount >= 2**pSelLen) begin : g_bad_cfg
    $error("status slot collides with a peripheral slot: pPeriCount must be < 2**pSelLen");
  end

  logic       status_hit;
  logic [7:0] status_cnt_q;

  assign status_hit = (sel_in == STATUS_SEL);
  assign idle_rdat  = status_hit ? pDataLen'(status_cnt_q) : '0;

  // A clearing write wins over a timeout landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_cnt_q <= '0;
    end else if (start && status_hit && wbc_we) begin
      status_cnt_q <= '0;
    end else if (timeout_evt && (status_cnt_q != 8'hFF)) begin
      status_cnt_q <= status_cnt_q + 8'd1;
    end
  end
`else
  assign idle_rdat = '0;
`endif

  // Route the selected slot's ack and read data. Only slots that exist are
  // decoded, so an unmapped sel never indexes past the packed buses.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path leaves it unassigned and infers a latch.
    ack_hit   = 1'b0;
    slot_rdat = '0;
    wbp_stb   = '0;
    for (int i = 0; i < pPeriCount; i++) begin
      if (sel_q == pSelLen'(i)) begin
        ack_hit    = wbp_ack[i];
        slot_rdat  = wbp_rdat[i*pDataLen +: pDataLen];
        wbp_stb[i] = (state_q == BUSY);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (wbc_stb) state_d = sel_mapped ? BUSY : RESP;
      BUSY:     if (ack_hit || cnt_done) state_d = RESP;
      RESP:     state_d = WAIT_LOW;
      WAIT_LOW: if (!wbc_stb) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so every register samples the pre-edge values of the others.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the latched request fields are reset along with the FSM because every output must read 0 while rst_n is low.
    if (!rst_n) begin
      sel_q  <= '0;
      adr_q  <= '0;
      we_q   <= 1'b0;
      dat_q  <= '0;
      rdat_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      if (start) begin
        sel_q <= sel_in;
        adr_q <= wbc_adr[LOC_LEN-1:0];
        we_q  <= wbc_we;
        dat_q <= wbc_dat;
        cnt_q <= '0;
        err_q <= 1'b0;
        if (!sel_mapped) rdat_q <= idle_rdat;
      end
      if (state_q == BUSY) begin
        // The counter stops at its last value, so it never wraps.
        if (!cnt_done) cnt_q <= cnt_q + 1'b1;
        if (ack_hit) begin
          rdat_q <= slot_rdat;
          err_q  <= 1'b0;
        end else if (cnt_done) begin
          rdat_q <= '1;
          err_q  <= 1'b1;
          seen_q <= 1'b1;
        end
      end
    end
  end

  assign wbc_rdat     = rdat_q;
  assign wbc_ack      = (state_q == RESP);
  assign wbc_err      = (state_q == RESP) && err_q;
  assign wbp_we       = we_q;
  assign wbp_adr      = adr_q;
  assign wbp_dat      = dat_q;
  assign timeout_seen = seen_q;

endmodule

// File: tb/tb_wishbone_interconnect.sv
// -----------------------------------------------------------------------------
// tb_wishbone_interconnect
//
// Bench for wishbone_interconnect with default parameters (4-bit address,
// 2 select bits, 8-bit data, 3 peripherals, 16-cycle timeout). A behavioural
// peripheral model answers each strobe after a programmed number of strobe
// cycles. Expected results come from a fixed vector table and from a
// transaction-level reference model that works in cycle counts.
// -----------------------------------------------------------------------------
module tb_wishbone_interconnect;

  localparam int PERI  = 3;
  localparam int TMO   = 16;
  localparam int NEVER = 1000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wbc_stb = 1'b0;
  logic            wbc_we = 1'b0;
  logic [3:0]      wbc_adr = '0;
  logic [7:0]      wbc_dat = '0;
  logic [7:0]      wbc_rdat;
  logic            wbc_ack;
  logic            wbc_err;
  logic [PERI-1:0] wbp_stb;
  logic            wbp_we;
  logic [1:0]      wbp_adr;
  logic [7:0]      wbp_dat;
  logic [PERI*8-1:0] wbp_rdat = '0;
  logic [PERI-1:0] wbp_ack = '0;
  logic            timeout_seen;

  wishbone_interconnect #(
    .pAddrLen(4), .pSelLen(2), .pDataLen(8), .pPeriCount(PERI), .pTimeoutCycles(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wbc_stb(wbc_stb), .wbc_we(wbc_we), .wbc_adr(wbc_adr), .wbc_dat(wbc_dat),
    .wbc_rdat(wbc_rdat), .wbc_ack(wbc_ack), .wbc_err(wbc_err),
    .wbp_stb(wbp_stb), .wbp_we(wbp_we), .wbp_adr(wbp_adr), .wbp_dat(wbp_dat),
    .wbp_rdat(wbp_rdat), .wbp_ack(wbp_ack), .timeout_seen(timeout_seen)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: sticky timeout flag and saturating timeout count.
  bit m_seen = 1'b0;
  int m_cnt  = 0;

  // The peripheral model acks when the number of strobe cycles seen so far
  // equals lat_cfg. Non-strobed slots may emit stray acks when noise_en is set.
  int lat_cfg [PERI];
  int pcnt    [PERI];
  bit noise_en = 1'b0;

  initial begin
    for (int i = 0; i < PERI; i++) begin
      lat_cfg[i] = NEVER;
      pcnt[i]    = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < PERI; i++) begin
      if (wbp_stb[i]) begin
        wbp_ack[i] = (pcnt[i] == lat_cfg[i]);
        pcnt[i]    = pcnt[i] + 1;
      end else begin
        pcnt[i]    = 0;
        wbp_ack[i] = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Transaction-level expectation derived from the access rules. A mapped slot
  // that answers within the timeout window is strobed lat+1 cycles, and its ack
  // appears one cycle later. Otherwise the strobe lasts the whole window and a
  // forced error follows. Unmapped accesses answer on the next cycle.
  task automatic model(input logic [3:0] adr, input bit we, input logic [7:0] pval,
                       input int lat, output logic [7:0] e_rdat, output bit e_err,
                       output int e_ack, output int e_stb);
    int sel;
    sel = int'(adr[3:2]);
    if (sel < PERI) begin
      if (lat < TMO) begin
        e_rdat = pval; e_err = 1'b0; e_stb = lat + 1; e_ack = lat + 2;
      end else begin
        e_rdat = 8'hFF; e_err = 1'b1; e_stb = TMO; e_ack = TMO + 1;
        m_seen = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
    end else begin
      e_err = 1'b0; e_stb = 0; e_ack = 1;
`ifdef WB_INTERCONNECT_STATUS_EN
      e_rdat = m_cnt[7:0];
      if (we) m_cnt = 0;
`else
      e_rdat = 8'h00;
`endif
    end
  endtask

  // Drive one controller access. Keep the strobe high for `hold` cycles after
  // the ack, then drop it and let the interconnect return to idle.
  task automatic run_txn(input logic [3:0] adr, input bit we, input logic [7:0] dat,
                         input logic [7:0] pval, input int lat, input int hold,
                         input logic [7:0] e_rdat, input bit e_err, input int e_ack,
                         input int e_stb, input bit e_seen, input string name);
    int sel;
    int ack_at = -1;
    int acks = 0;
    int stbs = 0;
    int bad_stb = 0;
    int bad_fwd = 0;
    logic [7:0] got_rdat = '0;
    logic got_err = 1'b0;
    logic [PERI-1:0] exp_onehot;
    sel = int'(adr[3:2]);
    exp_onehot = '0;
    @(negedge clk);
    for (int i = 0; i < PERI; i++) begin
      lat_cfg[i] = NEVER;
      wbp_rdat[i*8 +: 8] = 8'($urandom);
    end
    if (sel < PERI) begin
      lat_cfg[sel] = lat;
      wbp_rdat[sel*8 +: 8] = pval;
      exp_onehot[sel] = 1'b1;
    end
    wbc_stb = 1'b1; wbc_we = we; wbc_adr = adr; wbc_dat = dat;
    for (int c = 1; c <= TMO + hold + 8; c++) begin
      @(posedge clk); #1;
      if (wbp_stb != '0) begin
        stbs++;
        if (wbp_stb !== exp_onehot) bad_stb++;
        if (wbp_we !== we || wbp_adr !== adr[1:0] || wbp_dat !== dat) bad_fwd++;
      end
      if (wbc_ack) begin
        acks++;
        if (ack_at < 0) begin
          ack_at = c; got_rdat = wbc_rdat; got_err = wbc_err;
        end
      end
      if (ack_at >= 0 && c >= ack_at + hold) break;
    end
    @(negedge clk);
    wbc_stb = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (wbc_ack) acks++;
      if (wbp_stb != '0) stbs++;
    end
    check({name, " ack_latency"}, 32'(ack_at), 32'(e_ack));
    check({name, " ack_count"}, 32'(acks), 32'd1);
    check({name, " rdat"}, 32'(got_rdat), 32'(e_rdat));
    check({name, " err"}, 32'(got_err), 32'(e_err));
    check({name, " stb_cycles"}, 32'(stbs), 32'(e_stb));
    check({name, " stb_onehot"}, 32'(bad_stb), 32'd0);
    check({name, " fwd_fields"}, 32'(bad_fwd), 32'd0);
    check({name, " timeout_seen"}, 32'(timeout_seen), 32'(e_seen));
  endtask

  typedef struct {
    logic [3:0] adr;
    bit         we;
    logic [7:0] dat;
    logic [7:0] pval;
    int         lat;
    int         hold;
    logic [7:0] e_rdat;
    bit         e_err;
    int         e_ack;
    int         e_stb;
    bit         e_seen;
    string      name;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r_adr;
    bit         r_we;
    logic [7:0] r_dat, r_pval, e_rdat;
    bit         e_err;
    int         r_lat, r_hold, e_ack, e_stb;
    int         lat_pick;

    vecs[0] = '{4'b0110, 1'b0, 8'h00, 8'hA5, 0,     0, 8'hA5, 1'b0, 2,       1,   1'b0, "read_mapped"};
    vecs[1] = '{4'b0001, 1'b1, 8'h3C, 8'h77, 2,     0, 8'h77, 1'b0, 4,       3,   1'b0, "write_mapped"};
    vecs[2] = '{4'b1100, 1'b0, 8'h11, 8'h00, NEVER, 9, 8'h00, 1'b0, 1,       0,   1'b0, "unmapped_stuck"};
    vecs[3] = '{4'b1000, 1'b0, 8'h00, 8'h00, NEVER, 0, 8'hFF, 1'b1, TMO + 1, TMO, 1'b1, "timeout"};
    vecs[4] = '{4'b0100, 1'b0, 8'h00, 8'h5A, TMO-1, 0, 8'h5A, 1'b0, TMO + 1, TMO, 1'b1, "ack_on_last_cycle"};
    vecs[5] = '{4'b0011, 1'b0, 8'h00, 8'hC3, 1,     0, 8'hC3, 1'b0, 3,       2,   1'b1, "back_to_back"};

    // Reset state: every output low while rst_n is held.
    #2;
    check("reset_outputs", {wbc_rdat, wbc_ack, wbc_err, wbp_stb, wbp_we, wbp_adr, wbp_dat, timeout_seen}, '0);
    repeat (3) @(negedge clk);
    check("reset_outputs_clocked", {wbc_rdat, wbc_ack, wbc_err, wbp_stb, wbp_we, wbp_adr, wbp_dat, timeout_seen}, '0);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      run_txn(vecs[v].adr, vecs[v].we, vecs[v].dat, vecs[v].pval, vecs[v].lat, vecs[v].hold,
              vecs[v].e_rdat, vecs[v].e_err, vecs[v].e_ack, vecs[v].e_stb, vecs[v].e_seen,
              vecs[v].name);
    end
    // One timeout occurred in the table above.
    m_seen = 1'b1;
    m_cnt  = 1;

    // Randomized accesses with stray acks from non-selected slots.
    noise_en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      r_adr  = 4'($urandom_range(0, 15));
      r_we   = 1'($urandom_range(0, 1));
      r_dat  = 8'($urandom);
      r_pval = 8'($urandom);
      r_hold = $urandom_range(0, 3);
      lat_pick = $urandom_range(0, 8);
      if (lat_pick < 6)       r_lat = lat_pick;
      else if (lat_pick == 6) r_lat = TMO - 1;
      else if (lat_pick == 7) r_lat = TMO;
      else                    r_lat = NEVER;
      model(r_adr, r_we, r_pval, r_lat, e_rdat, e_err, e_ack, e_stb);
      run_txn(r_adr, r_we, r_dat, r_pval, r_lat, r_hold, e_rdat, e_err, e_ack, e_stb, m_seen, "random");
    end
    noise_en = 1'b0;

    // Reset in the middle of a slot-1 strobe: outputs drop without waiting for a clock.
    check("pre_reset_seen", 32'(timeout_seen), 32'(m_seen));
    @(negedge clk);
    for (int i = 0; i < PERI; i++) lat_cfg[i] = NEVER;
    wbc_stb = 1'b1; wbc_we = 1'b0; wbc_adr = 4'b0101;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy_stb", 32'(wbp_stb), 32'b010);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_stb", 32'(wbp_stb), 32'd0);
    check("async_reset_ack", 32'(wbc_ack), 32'd0);
    check("async_reset_seen", 32'(timeout_seen), 32'd0);
    @(negedge clk);
    wbc_stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_seen = 1'b0;
    m_cnt  = 0;
    repeat (3) begin
      @(posedge clk); #1;
      check("no_ack_after_reset", 32'(wbc_ack), 32'd0);
    end
    run_txn(4'b0010, 1'b0, 8'h00, 8'h96, 0, 0, 8'h96, 1'b0, 2, 1, 1'b0, "read_after_reset");

`ifdef WB_INTERCONNECT_STATUS_EN
    // Status register: two timeouts, read the count, clear it, read again.
    for (int k = 0; k < 2; k++) begin
      model(4'b1001, 1'b0, 8'h00, NEVER, e_rdat, e_err, e_ack, e_stb);
      run_txn(4'b1001, 1'b0, 8'h00, 8'h00, NEVER, 0, e_rdat, e_err, e_ack, e_stb, m_seen, "status_timeout");
    end
    model(4'b1100, 1'b0, 8'h00, 0, e_rdat, e_err, e_ack, e_stb);
    check("status_model_count", 32'(e_rdat), 32'h02);
    run_txn(4'b1100, 1'b0, 8'h00, 8'h00, 0, 0, e_rdat, e_err, e_ack, e_stb, m_seen, "status_read");
    model(4'b1100, 1'b1, 8'h00, 0, e_rdat, e_err, e_ack, e_stb);
    run_txn(4'b1100, 1'b1, 8'hAA, 8'h00, 0, 0, e_rdat, e_err, e_ack, e_stb, m_seen, "status_clear");
    model(4'b1100, 1'b0, 8'h00, 0, e_rdat, e_err, e_ack, e_stb);
    run_txn(4'b1100, 1'b0, 8'h00, 8'h00, 0, 0, 8'h00, e_err, e_ack, e_stb, m_seen, "status_read_cleared");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
